// File: rtl/button_poll_pkg.sv
// Shared types and constants for the button poll master.
package button_poll_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2
    } poll_state_e;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

endpackage

// File: rtl/button_poll_master_if.sv
// Avalon-MM read-only link between the poll master and the button PIO slave.
interface button_poll_master_if;

    logic [1:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata
    );

endinterface

// File: rtl/button_debounce_bit.sv
// Single-bit debouncer: the stable level flips only after DEBOUNCE_N
// consecutive differing samples, emitting a one-cycle press or release pulse.
module button_debounce_bit #(
    parameter int DEBOUNCE_N = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample_en,
    input  logic raw,
    output logic stable,
    output logic press,
    output logic release_evt
);

    localparam int              CNT_W    = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_N - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             stable_r;
    logic             stable_nxt_s;
    logic             press_r;
    logic             press_nxt_s;
    logic             rel_r;
    logic             rel_nxt_s;

    // Debounce decision, evaluated only on a captured sample
    always_comb begin
        cnt_nxt_s    = cnt_r;
        stable_nxt_s = stable_r;
        press_nxt_s  = 1'b0;
        rel_nxt_s    = 1'b0;
        if (sample_en) begin
            if (raw == stable_r) begin
                cnt_nxt_s = '0;
            end else if (cnt_r == CNT_LAST) begin
                stable_nxt_s = raw;
                cnt_nxt_s    = '0;
                press_nxt_s  = raw;
                rel_nxt_s    = ~raw;
            end else begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Debounce state and registered event outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r    <= '0;
            stable_r <= 1'b0;
            press_r  <= 1'b0;
            rel_r    <= 1'b0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            stable_r <= stable_nxt_s;
            press_r  <= press_nxt_s;
            rel_r    <= rel_nxt_s;
        end
    end

    assign stable      = stable_r;
    assign press       = press_r;
    assign release_evt = rel_r;

endmodule

// File: rtl/button_poll_master.sv
// Periodically reads the button PIO data register over Avalon-MM and
// debounces each bit into stable levels plus press/release pulses.
module button_poll_master
    import button_poll_pkg::*;
#(
    parameter int WIDTH        = 2,
    parameter int POLL_DIV     = 50000,
    parameter int READ_LATENCY = 1,
    parameter int DEBOUNCE_N   = 4,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    button_poll_master_if.master avm,
    output logic [WIDTH-1:0]     buttons,
    output logic [WIDTH-1:0]     press,
    output logic [WIDTH-1:0]     release_evt,
    output logic                 sample_valid
);

    localparam int               PCNT_W    = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(POLL_DIV - 1);
    localparam int               WCNT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(READ_LATENCY - 1);
    localparam logic [WIDTH-1:0]  RAW_MASK  = {WIDTH{ACTIVE_LOW}};

    poll_state_e       state_r;
    poll_state_e       state_nxt_s;
    logic [PCNT_W-1:0] pcnt_r;
    logic [WCNT_W-1:0] wcnt_r;
    logic              poll_hit_s;
    logic              capture_s;
    logic              read_nxt_s;
    logic              avm_read_r;
    logic              sample_valid_r;
    logic [WIDTH-1:0]  raw_s;
    logic              unused_rd_s;

    assign poll_hit_s  = enable && (pcnt_r == PCNT_LAST);
    assign capture_s   = (state_r == WAIT) && (wcnt_r == WCNT_LAST);
    assign unused_rd_s = ^avm.avm_readdata[31:WIDTH];

    // Free-running poll divider; keeps counting through READ/WAIT so the period is exact
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_r <= '0;
        end else if (!enable || (pcnt_r == PCNT_LAST)) begin
            pcnt_r <= '0;
        end else begin
            pcnt_r <= pcnt_r + PCNT_W'(1);
        end
    end

    // Read-latency counter, only meaningful while in WAIT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt_r <= '0;
        end else if ((state_r == WAIT) && !capture_s) begin
            wcnt_r <= wcnt_r + WCNT_W'(1);
        end else begin
            wcnt_r <= '0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; an in-flight read always completes regardless of enable
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = poll_hit_s ? READ : IDLE;
            READ:    state_nxt_s = WAIT;
            WAIT:    state_nxt_s = capture_s ? IDLE : WAIT;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs, computed one cycle ahead so the Avalon strobe is registered
    always_comb begin
        read_nxt_s = (state_nxt_s == READ);
        raw_s      = avm.avm_readdata[WIDTH-1:0] ^ RAW_MASK;
    end

    // Registered Avalon strobe and sample pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avm_read_r     <= 1'b0;
            sample_valid_r <= 1'b0;
        end else begin
            avm_read_r     <= read_nxt_s;
            sample_valid_r <= capture_s;
        end
    end

    assign avm.avm_address = PIO_DATA_ADDR;
    assign avm.avm_read    = avm_read_r;
    assign sample_valid    = sample_valid_r;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        button_debounce_bit #(
            .DEBOUNCE_N (DEBOUNCE_N)
        ) u_debounce (
            .clk         (clk),
            .reset_n     (reset_n),
            .sample_en   (capture_s),
            .raw         (raw_s[i]),
            .stable      (buttons[i]),
            .press       (press[i]),
            .release_evt (release_evt[i])
        );
    end

endmodule

// File: tb/tb_button_poll_master.sv
// Self-checking bench: registered PIO slave model plus a debounce scoreboard,
// with per-scenario cycle-exact checks.
module tb_button_poll_master;

    localparam int DB_N = 3;

    typedef struct packed {
        logic [1:0]      stable;
        logic [1:0][1:0] cnt;
        logic [1:0]      press;
        logic [1:0]      rel;
    } mstep_t;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic [1:0] in_port;
    logic [1:0] buttons;
    logic [1:0] press;
    logic [1:0] release_evt;
    logic       sample_valid;

    int n_cmp;
    int n_err;

    logic [1:0]      m_stable;
    logic [1:0][1:0] m_cnt;
    mstep_t          m_next;
    mstep_t          sb_q[$];

    button_poll_master_if bus ();

    button_poll_master #(
        .WIDTH        (2),
        .POLL_DIV     (8),
        .READ_LATENCY (1),
        .DEBOUNCE_N   (DB_N),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .avm          (bus),
        .buttons      (buttons),
        .press        (press),
        .release_evt  (release_evt),
        .sample_valid (sample_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mstep_t model_step(input logic [1:0] raw, input logic [1:0] st,
                                          input logic [1:0][1:0] cnt);
        mstep_t r;
        r        = '0;
        r.stable = st;
        r.cnt    = cnt;
        for (int i = 0; i < 2; i++) begin
            if (raw[i] == st[i]) begin
                r.cnt[i] = 2'd0;
            end else if (cnt[i] == 2'(DB_N - 1)) begin
                r.stable[i] = raw[i];
                r.cnt[i]    = 2'd0;
                if (raw[i]) r.press[i] = 1'b1;
                else        r.rel[i]   = 1'b1;
            end else begin
                r.cnt[i] = cnt[i] + 2'd1;
            end
        end
        return r;
    endfunction

    assign m_next = model_step(~in_port, m_stable, m_cnt);

    // PIO slave with registered readdata (junk when idle) plus the debounce model
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.avm_readdata <= 32'd0;
            m_stable         <= 2'b00;
            m_cnt            <= '0;
            sb_q.delete();
        end else if (bus.avm_read) begin
            bus.avm_readdata <= {30'($urandom()), in_port};
            m_stable         <= m_next.stable;
            m_cnt            <= m_next.cnt;
            sb_q.push_back(m_next);
        end else begin
            bus.avm_readdata <= $urandom();
        end
    end

    // Scoreboard: compare each captured sample, and forbid stray pulses otherwise
    always @(negedge clk) begin
        if (reset_n) begin
            if (sample_valid) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_underflow: sample_valid with no outstanding read");
                end else begin
                    if ({buttons, press, release_evt} !== {sb_q[0].stable, sb_q[0].press, sb_q[0].rel}) begin
                        n_err++;
                        $display("FAIL sb_sample: got btn=%b prs=%b rel=%b want btn=%b prs=%b rel=%b",
                                 buttons, press, release_evt, sb_q[0].stable, sb_q[0].press, sb_q[0].rel);
                    end
                    void'(sb_q.pop_front());
                end
            end else begin
                n_cmp++;
                if ((press | release_evt) !== 2'b00) begin
                    n_err++;
                    $display("FAIL stray_pulse: prs=%b rel=%b want 00 without sample_valid", press, release_evt);
                end
            end
        end
    end

    task automatic do_reset(input logic [1:0] in_v, input logic en_v);
        @(negedge clk);
        reset_n = 1'b0;
        in_port = in_v;
        enable  = en_v;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset_n = 1'b0;
        enable  = 1'b1;
        in_port = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.avm_read, bus.avm_address, buttons, press, release_evt, sample_valid} !== 10'd0) begin
                n_err++;
                $display("FAIL reset_values: got rd=%b addr=%0d btn=%b prs=%b rel=%b sv=%b want all 0",
                         bus.avm_read, bus.avm_address, buttons, press, release_evt, sample_valid);
            end
        end
        reset_n = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            logic exp_rd;
            logic exp_sv;
            @(posedge clk);
            #1;
            exp_rd = (c % 8 == 0);
            exp_sv = (c >= 10) && (c % 8 == 2);
            n_cmp++;
            if (bus.avm_read !== exp_rd) begin
                n_err++;
                $display("FAIL read_timing c=%0d: got %b want %b", c, bus.avm_read, exp_rd);
            end
            n_cmp++;
            if (sample_valid !== exp_sv) begin
                n_err++;
                $display("FAIL sv_timing c=%0d: got %b want %b", c, sample_valid, exp_sv);
            end
            n_cmp++;
            if (bus.avm_address !== 2'd0) begin
                n_err++;
                $display("FAIL address c=%0d: got %0d want 0", c, bus.avm_address);
            end
        end
    endtask

    task automatic test_clean_press;
        do_reset(2'b10, 1'b1);
        for (int c = 1; c <= 40; c++) begin
            logic [1:0] exp_p;
            logic [1:0] exp_b;
            @(posedge clk);
            #1;
            exp_p = (c == 26) ? 2'b01 : 2'b00;
            exp_b = (c >= 26) ? 2'b01 : 2'b00;
            n_cmp++;
            if ({buttons, press, release_evt} !== {exp_b, exp_p, 2'b00}) begin
                n_err++;
                $display("FAIL clean_press c=%0d: got btn=%b prs=%b rel=%b want btn=%b prs=%b rel=00",
                         c, buttons, press, release_evt, exp_b, exp_p);
            end
        end
    endtask

    task automatic test_glitch;
        do_reset(2'b11, 1'b1);
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({buttons, press, release_evt} !== 6'd0) begin
                n_err++;
                $display("FAIL glitch c=%0d: got btn=%b prs=%b rel=%b want all 0",
                         c, buttons, press, release_evt);
            end
            if (c == 12 || c == 36) in_port = 2'b10;
            if (c == 28 || c == 52) in_port = 2'b11;
        end
    endtask

    task automatic test_simultaneous;
        do_reset(2'b01, 1'b1);
        for (int c = 1; c <= 56; c++) begin
            logic [1:0] exp_b;
            logic [1:0] exp_p;
            logic [1:0] exp_r;
            @(posedge clk);
            #1;
            exp_b = (c < 26) ? 2'b00 : ((c < 50) ? 2'b10 : 2'b01);
            exp_p = (c == 26) ? 2'b10 : ((c == 50) ? 2'b01 : 2'b00);
            exp_r = (c == 50) ? 2'b10 : 2'b00;
            n_cmp++;
            if ({buttons, press, release_evt} !== {exp_b, exp_p, exp_r}) begin
                n_err++;
                $display("FAIL simultaneous c=%0d: got btn=%b prs=%b rel=%b want btn=%b prs=%b rel=%b",
                         c, buttons, press, release_evt, exp_b, exp_p, exp_r);
            end
            if (c == 27) in_port = 2'b10;
        end
    endtask

    task automatic test_enable_drop;
        do_reset(2'b11, 1'b1);
        for (int c = 1; c <= 48; c++) begin
            logic exp_rd;
            logic exp_sv;
            @(posedge clk);
            #1;
            exp_rd = (c == 8) || (c == 38) || (c == 46);
            exp_sv = (c == 10) || (c == 40) || (c == 48);
            n_cmp++;
            if ({bus.avm_read, sample_valid} !== {exp_rd, exp_sv}) begin
                n_err++;
                $display("FAIL enable_drop c=%0d: got rd=%b sv=%b want rd=%b sv=%b",
                         c, bus.avm_read, sample_valid, exp_rd, exp_sv);
            end
            if (c == 8)  enable = 1'b0;
            if (c == 30) enable = 1'b1;
        end
    endtask

    task automatic test_reset_mid;
        do_reset(2'b10, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({buttons, press} !== 4'd0) begin
                n_err++;
                $display("FAIL mid_pre c=%0d: got btn=%b prs=%b want 00/00", c, buttons, press);
            end
        end
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({bus.avm_read, buttons, press, release_evt, sample_valid} !== 8'd0) begin
                n_err++;
                $display("FAIL mid_reset: got rd=%b btn=%b prs=%b rel=%b sv=%b want all 0",
                         bus.avm_read, buttons, press, release_evt, sample_valid);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            logic [1:0] exp_p;
            logic [1:0] exp_b;
            @(posedge clk);
            #1;
            exp_p = (c == 26) ? 2'b01 : 2'b00;
            exp_b = (c >= 26) ? 2'b01 : 2'b00;
            n_cmp++;
            if ({buttons, press, release_evt} !== {exp_b, exp_p, 2'b00}) begin
                n_err++;
                $display("FAIL mid_post c=%0d: got btn=%b prs=%b rel=%b want btn=%b prs=%b rel=00",
                         c, buttons, press, release_evt, exp_b, exp_p);
            end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        enable  = 1'b0;
        in_port = 2'b11;
        test_reset();
        test_clean_press();
        test_glitch();
        test_simultaneous();
        test_enable_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
